pc_target_table: RTL and testbench
==================================

// Module: pc_target_table
// PURPOSE
//  Writable, parametrised branch-target table; successor to the fixed 16-entry PC lookup.
//  Fetch stage issues an index; table returns the absolute target one cycle later.
//  Each entry holds either an absolute target or a signed PC-relative offset (compile option).
//  Each entry has a valid bit. Contents are cleared by an init sequencer after every reset.
//  Entries are programmed at run time through a write port.
// PARAMETERS
//  AW  4   index width; depth = 2**AW entries
//  D   10  target/PC width; all target arithmetic is modulo 2**D
// PORTS
//  clk        in   1   sole clock, rising edge
//  reset      in   1   synchronous, active-high
//  init_done  out  1   table cleared and accepting requests
//  wr_en      in   1   write strobe, sampled at posedge
//  wr_addr    in   AW  entry to write
//  wr_data    in   D   absolute target, or two's-complement offset when wr_rel=1
//  wr_rel     in   1   entry is PC-relative (ignored unless PCT_RELATIVE_EN)
//  rd_req     in   1   lookup request, sampled at posedge
//  rd_addr    in   AW  entry to look up
//  pc         in   D   current PC, captured with rd_req
//  rd_valid   out  1   one-cycle pulse: rd_target/rd_miss valid
//  rd_target  out  D   resolved target; 0 on miss
//  rd_miss    out  1   looked-up entry has never been written since init
// BEHAVIOUR
//  - Reset (held >=1 cycle) forces the following registered values:
//    state=INIT, clr_ptr=0, init_done=0, rd_valid=0, rd_target=0, rd_miss=0.
//  - FSM INIT: each cycle clears entry[clr_ptr] ({valid,rel,data}=0) and increments clr_ptr.
//    When clr_ptr==2**AW-1 it moves to READY. init_done goes 1 exactly 2**AW cycles after reset falls.
//  - INIT: wr_en and rd_req are ignored (no write, no rd_valid).
//  - FSM READY: stays in READY until reset. A reset in READY restarts INIT and clears every entry;
//    any read in flight is dropped (rd_valid=0 the next cycle).
//  - Write: wr_en at posedge stores {1,wr_rel,wr_data} to entry[wr_addr].
//  - Read latency is 1 cycle. rd_req at edge N sets rd_valid=1 after edge N+1, else rd_valid=0.
//    Back-to-back requests produce back-to-back results.
//  - Result when the entry is valid: rd_target = rel ? (pc + data) mod 2**D : data.
//    pc and data are both D bits; carry and borrow are discarded.
//  - Result when the entry is invalid: rd_miss=1, rd_target=0.
//  - Same-cycle write and read to the same address is write-first: the read returns the new entry.
//  - rd_target and rd_miss hold their last value while rd_valid=0.
// CONFIGURATION
//  PCT_RELATIVE_EN defined:
//    rel bit is stored; relative entries resolve to pc+offset as above.
//  PCT_RELATIVE_EN undefined:
//    rel bit is not stored; wr_rel and pc are ignored; every entry is absolute;
//    the adder is removed.
// STRUCTURE
//  Package pc_table_pkg holds:
//    - typedef enum logic {PCT_INIT, PCT_READY} pct_state_t
//    - parameterised entry struct {valid, rel, data}, written as a function of D or in-module typedef
//  Optional sub-module pct_resolve: combinational abs/rel target resolver,
//    instantiated only under PCT_RELATIVE_EN.
//  Storage is a flop array with a write-first bypass mux.
// TESTING (AW=4, D=10)
//  1. Reset 1 cycle, release.
//     -> init_done=0 for 16 cycles, then 1.
//     -> rd_req during INIT gives no rd_valid.
//  2. Write addr2=41 abs; next cycle rd_req addr2.
//     -> one cycle later: rd_valid=1, rd_target=41, rd_miss=0.
//  3. rd_req addr9, never written.
//     -> rd_valid=1, rd_miss=1, rd_target=0.
//  4. (PCT_RELATIVE_EN) Write addr4 data 10'h3FB (-5) rel.
//     -> read with pc=20 gives 15.
//     -> read with pc=3 gives 1022 (wrap).
//  5. Same edge: wr addr7=97 and rd_req addr7.
//     -> rd_target=97, rd_miss=0.
//     Separately, 3 consecutive rd_req -> 3 consecutive rd_valid.
//  6. Write entries 0..3, then reset mid-stream with rd_req pending.
//     -> the pending read is dropped.
//     -> after a 16-cycle init, reads of 0..3 give rd_miss=1.

Source files
------------

// File: rtl/pc_table_pkg.sv
// ---------------------------------------------------------------------------
// pc_table_pkg
// Shared types and defaults for the writable branch-target table.
//   pct_state_t    : init sequencer state (clearing vs. accepting requests)
//   PCT_AW_DEFAULT : default index width (depth = 2**AW)
//   PCT_D_DEFAULT  : default target/PC width
// The entry struct depends on the D parameter, so it is declared inside
// pc_target_table; pct_entry_width() gives its packed width for any D.
// ---------------------------------------------------------------------------
package pc_table_pkg;

  typedef enum logic {
    PCT_INIT  = 1'b0,
    PCT_READY = 1'b1
  } pct_state_t;

  localparam int PCT_AW_DEFAULT = 4;
  localparam int PCT_D_DEFAULT  = 10;

  // Packed width of one {valid, rel, data} entry.
  function automatic int pct_entry_width(input int d);
    return d + 2;
  endfunction

endpackage

// File: rtl/pct_resolve.sv
// ---------------------------------------------------------------------------
// pct_resolve
// Combinational target resolver for a table entry.
//   rel    in  1  entry holds a two's-complement offset from pc
//   data   in  D  absolute target or offset
//   pc     in  D  PC captured with the lookup request
//   target out D  rel ? (pc + data) mod 2**D : data
// Carry out of the adder is dropped, so negative offsets wrap naturally.
// ---------------------------------------------------------------------------
module pct_resolve
  import pc_table_pkg::*;
#(
  parameter int D = PCT_D_DEFAULT
) (
  input  logic         rel,
  input  logic [D-1:0] data,
  input  logic [D-1:0] pc,
  output logic [D-1:0] target
);

  logic [D-1:0] sum;

  assign sum    = pc + data;
  assign target = rel ? sum : data;

endmodule

// File: rtl/pc_target_table.sv
// ---------------------------------------------------------------------------
// pc_target_table
// Writable branch-target table. The fetch stage issues an index and the
// absolute target comes back one cycle later. Every entry carries a valid bit;
// an init sequencer clears all entries after each reset, one per cycle.
//
// Build option: define PCT_RELATIVE_EN to store a per-entry rel bit and
// resolve relative entries as pc + offset. Without it wr_rel and pc are
// ignored and every entry is absolute.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high
//   init_done  out  1   table cleared and accepting requests
//   wr_en      in   1   write strobe
//   wr_addr    in   AW  entry to write
//   wr_data    in   D   absolute target or signed offset
//   wr_rel     in   1   entry is PC-relative (PCT_RELATIVE_EN only)
//   rd_req     in   1   lookup request
//   rd_addr    in   AW  entry to look up
//   pc         in   D   current PC, captured with rd_req
//   rd_valid   out  1   one-cycle pulse, rd_target/rd_miss valid
//   rd_target  out  D   resolved target, 0 on miss
//   rd_miss    out  1   entry not written since init
// ---------------------------------------------------------------------------
module pc_target_table
  import pc_table_pkg::*;
#(
  parameter int AW = PCT_AW_DEFAULT,
  parameter int D  = PCT_D_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  output logic          init_done,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [D-1:0]  wr_data,
  input  logic          wr_rel,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [D-1:0]  pc,
  output logic          rd_valid,
  output logic [D-1:0]  rd_target,
  output logic          rd_miss
);

  localparam int DEPTH = 2**AW;
  localparam int EW    = pct_entry_width(D);

  typedef struct packed {
    logic         valid;
    logic         rel;
    logic [D-1:0] data;
  } pct_entry_t;

  // ---------------------------------------------------------------- FSM ----
  pct_state_t    state_reg, state_next;
  logic [AW-1:0] clr_ptr_reg, clr_ptr_next;
  logic          init_done_reg, init_done_next;
  logic          ready;

  assign ready = (state_reg == PCT_READY);

  always_comb begin
    state_next     = state_reg;
    clr_ptr_next   = clr_ptr_reg;
    init_done_next = init_done_reg;
    case (state_reg)
      PCT_INIT: begin
        clr_ptr_next = clr_ptr_reg + AW'(1);
        // Last entry is cleared on this edge; requests are taken from the next.
        if (clr_ptr_reg == {AW{1'b1}}) begin
          state_next     = PCT_READY;
          init_done_next = 1'b1;
        end
      end
      PCT_READY: begin
        state_next = PCT_READY;
      end
      default: begin
        state_next     = PCT_INIT;
        clr_ptr_next   = '0;
        init_done_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= PCT_INIT;
      clr_ptr_reg   <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_ptr_reg   <= clr_ptr_next;
      init_done_reg <= init_done_next;
    end
  end

  assign init_done = init_done_reg;

  // ------------------------------------------------------------ storage ----
  pct_entry_t              wr_entry;
  logic                    wr_hit;
  logic [DEPTH-1:0][EW-1:0] entries;

  assign wr_hit         = ready && wr_en;
  assign wr_entry.valid = 1'b1;
`ifdef PCT_RELATIVE_EN
  assign wr_entry.rel   = wr_rel;
`else
  assign wr_entry.rel   = 1'b0;
`endif
  assign wr_entry.data  = wr_data;

  // One flop row per entry: cleared by the init sequencer, otherwise written
  // by the write port. Both are blocked while reset is asserted.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      pct_entry_t entry_reg;

      always_ff @(posedge clk) begin
        if (!reset) begin
          if (!ready && (clr_ptr_reg == AW'(gi))) begin
            entry_reg <= '0;
          end else if (wr_hit && (wr_addr == AW'(gi))) begin
            entry_reg <= wr_entry;
          end
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  // ------------------------------------------------------- read stage 1 ----
  // Capture the addressed entry at the request edge. A write to the same
  // address on that edge is forwarded so the read sees the new contents.
  pct_entry_t rd_entry_next, rd_entry_reg;
  logic       rd_accept;
  logic       req_reg;

  assign rd_accept     = ready && rd_req;
  assign rd_entry_next = (wr_hit && (wr_addr == rd_addr)) ? wr_entry
                                                          : pct_entry_t'(entries[rd_addr]);

  always_ff @(posedge clk) begin
    if (reset) begin
      req_reg <= 1'b0;
    end else begin
      req_reg <= rd_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      rd_entry_reg <= rd_entry_next;
    end
  end

  // ---------------------------------------------------------- resolver ----
  logic [D-1:0] resolved;

`ifdef PCT_RELATIVE_EN
  logic [D-1:0] pc_reg;

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      pc_reg <= pc;
    end
  end

  pct_resolve #(
    .D (D)
  ) u_resolve (
    .rel    (rd_entry_reg.rel),
    .data   (rd_entry_reg.data),
    .pc     (pc_reg),
    .target (resolved)
  );
`else
  // Absolute-only build: pc, wr_rel and the rel field carry no information.
  logic unused_rel_inputs;

  assign unused_rel_inputs = ^{wr_rel, pc, rd_entry_reg.rel};
  assign resolved          = rd_entry_reg.data;
`endif

  // ------------------------------------------------------- read stage 2 ----
  logic         rd_valid_reg;
  logic [D-1:0] rd_target_reg;
  logic         rd_miss_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg  <= 1'b0;
      rd_target_reg <= '0;
      rd_miss_reg   <= 1'b0;
    end else if (req_reg) begin
      rd_valid_reg  <= 1'b1;
      rd_target_reg <= rd_entry_reg.valid ? resolved : '0;
      rd_miss_reg   <= !rd_entry_reg.valid;
    end else begin
      // Target and miss hold their last value between results.
      rd_valid_reg  <= 1'b0;
    end
  end

  assign rd_valid  = rd_valid_reg;
  assign rd_target = rd_target_reg;
  assign rd_miss   = rd_miss_reg;

endmodule

// File: tb/tb_pc_target_table.sv
// ---------------------------------------------------------------------------
// tb_pc_target_table
// Directed and random stimulus for pc_target_table (AW=4, D=10). A
// behavioural table model predicts, for every clock edge, the read result due
// one cycle later, the held target/miss values and init_done.
// ---------------------------------------------------------------------------
module tb_pc_target_table;

  localparam int AW = 4;
  localparam int D  = 10;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [D-1:0]  wr_data;
  logic          wr_rel;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [D-1:0]  pc;
  logic          rd_valid;
  logic [D-1:0]  rd_target;
  logic          rd_miss;

  pc_target_table #(.AW(AW), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_rel    (wr_rel),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .pc        (pc),
    .rd_valid  (rd_valid),
    .rd_target (rd_target),
    .rd_miss   (rd_miss)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Table model
  bit m_valid [N];
  bit m_rel   [N];
  int m_data  [N];
  bit m_ready;
  int m_init_cnt;
  bit pend_v;
  int pend_t;
  bit pend_m;
  bit exp_v;
  int last_t;
  bit last_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, obs, exp);
    end
  endtask

  // Apply the inputs sampled at this edge to the model.
  task automatic model_edge(input bit r, input bit we, input int wa, input int wd,
                            input bit wrel, input bit rq, input int ra, input int p);
    if (r) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_ready = 0; m_init_cnt = 0;
      pend_v = 0; exp_v = 0; last_t = 0; last_m = 0;
    end else begin
      exp_v = pend_v;
      if (pend_v) begin
        last_t = pend_t;
        last_m = pend_m;
      end
      pend_v = 0;
      if (m_ready) begin
        if (we) begin
          m_valid[wa] = 1;
`ifdef PCT_RELATIVE_EN
          m_rel[wa] = wrel;
`else
          m_rel[wa] = 0;
`endif
          m_data[wa] = wd;
        end
        if (rq) begin
          pend_v = 1;
          if (m_valid[ra]) begin
            pend_m = 0;
            pend_t = m_rel[ra] ? (p + m_data[ra]) % 1024 : m_data[ra];
          end else begin
            pend_m = 1;
            pend_t = 0;
          end
        end
      end else begin
        m_init_cnt++;
        if (m_init_cnt == N) m_ready = 1;
      end
    end
  endtask

  // One clock: drive, sample at the edge, compare 1 time unit later.
  task automatic step(input bit r, input bit we, input int wa, input int wd,
                      input bit wrel, input bit rq, input int ra, input int p);
    reset   = r;
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = D'(wd);
    wr_rel  = wrel;
    rd_req  = rq;
    rd_addr = AW'(ra);
    pc      = D'(p);
    @(posedge clk);
    cycle++;
    model_edge(r, we, wa, wd, wrel, rq, ra, p);
    #1;
    chk("rd_valid",  32'(rd_valid),  32'(exp_v));
    chk("rd_target", 32'(rd_target), 32'(last_t));
    chk("rd_miss",   32'(rd_miss),   32'(last_m));
    chk("init_done", 32'(init_done), 32'(m_ready));
    $display("cyc=%0d rst=%0b we=%0b wa=%0d wd=%0d rel=%0b rq=%0b ra=%0d pc=%0d -> v=%0b t=%0d m=%0b init_done=%0b",
             cycle, r, we, wa, wd, wrel, rq, ra, p, rd_valid, rd_target, rd_miss, init_done);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0; wr_rel = 0;
    rd_req = 0; rd_addr = '0; pc = '0;
    for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_rel[i] = 0; m_data[i] = 0; end
    m_ready = 0; m_init_cnt = 0; pend_v = 0; pend_t = 0; pend_m = 0;
    exp_v = 0; last_t = 0; last_m = 0;

    // 1. Reset, then init: writes and reads are ignored for 16 cycles.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, i, 100 + i, 0, 1, i, 0);
    idle();
    idle();

    // 2. Absolute write then read.
    step(0, 1, 2, 41, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0);
    idle();

    // 3. Never-written entry.
    step(0, 0, 0, 0, 0, 1, 9, 0);
    idle();

    // 4. Relative entry -5, with and without wrap.
    step(0, 1, 4, 10'h3FB, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4, 20);
    step(0, 0, 0, 0, 0, 1, 4, 3);
    idle();

    // 5. Same-edge write/read, then three back-to-back reads.
    step(0, 1, 7, 97, 0, 1, 7, 0);
    idle();
    step(0, 0, 0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 0, 1, 7, 0);
    idle();

    // 6. Fill 0..3, reset with a read in flight, reinit, read back as misses.
    for (int i = 0; i < 4; i++) step(0, 1, i, 200 + i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) idle();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, i, 0);
    idle();

    // Random traffic with occasional resets.
    for (int k = 0; k < 250; k++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 1) == 1), $urandom_range(0, N - 1),
           $urandom_range(0, 1023), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
           $urandom_range(0, N - 1), $urandom_range(0, 1023));
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
